// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and default sizing for the parameterised register file
package reg_file_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_N_RD     = 2;
    localparam int DEF_ZERO_REG = 1;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_LOAD = 2'd1,
        DUMP_SEND = 2'd2
    } dump_state_t;

endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - serial dump stream and control between register file and its consumer
interface reg_file_dump_if #(
    parameter int ADDR_W = reg_file_pkg::DEF_ADDR_W,
    parameter int DATA_W = reg_file_pkg::DEF_DATA_W
);
    logic              dump_start;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_busy;

    modport master (
        input  dump_start,
        input  dump_ready,
        output dump_valid,
        output dump_addr,
        output dump_data,
        output dump_busy
    );

    modport slave (
        output dump_start,
        output dump_ready,
        input  dump_valid,
        input  dump_addr,
        input  dump_data,
        input  dump_busy
    );
endinterface

// File: rtl/reg_file_dump_fsm.sv
// rtl/reg_file_dump_fsm.sv - walks every address once, presenting one held beat per register
module reg_file_dump_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ready,
    input  logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] ptr,
    output logic              valid,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    dump_state_t       state;
    dump_state_t       state_n;
    logic [ADDR_W-1:0] ptr_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= DUMP_IDLE;
            ptr   <= '0;
            addr  <= '0;
            data  <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            if (state == DUMP_LOAD) begin
                addr <= ptr;
                data <= load_data;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        case (state)
            DUMP_IDLE: begin
                if (start) begin
                    ptr_n   = '0;
                    state_n = DUMP_LOAD;
                end
            end
            DUMP_LOAD: begin
                state_n = DUMP_SEND;
            end
            DUMP_SEND: begin
                // The last register ends the dump instead of letting ptr roll over.
                if (ready) begin
                    if (ptr == LAST_PTR) begin
                        state_n = DUMP_IDLE;
                    end else begin
                        ptr_n   = ptr + 1'b1;
                        state_n = DUMP_LOAD;
                    end
                end
            end
            default: begin
                state_n = DUMP_IDLE;
            end
        endcase
    end

    assign valid = (state == DUMP_SEND);
    assign busy  = (state != DUMP_IDLE);

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - multi-read-port register file with write-first bypass and serial dump
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_RD     = DEF_N_RD,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [N_RD-1:0]          ren,
    input  logic [N_RD*ADDR_W-1:0]   raddr,
    output logic [N_RD*DATA_W-1:0]   rdata,
    reg_file_dump_if.master          dump
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_blocked;
    logic [ADDR_W-1:0] dump_ptr;
    logic [DATA_W-1:0] dump_word;
    logic              dump_zero;

    assign wr_blocked = (ZERO_REG != 0) && (waddr == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && !wr_blocked) begin
            mem[waddr] <= wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] a;
            logic              zero_hit;
            logic [DATA_W-1:0] word;
            logic [DATA_W-1:0] q;

            assign a        = raddr[gi*ADDR_W +: ADDR_W];
            assign zero_hit = (ZERO_REG != 0) && (a == '0);
            // Write-first: a same-cycle write to the read address wins over storage.
            assign word     = zero_hit              ? '0    :
                              (we && (waddr == a))  ? wdata :
                                                      mem[a];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    q <= '0;
                end else if (ren[gi]) begin
                    q <= word;
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = q;
        end
    endgenerate

    assign dump_zero = (ZERO_REG != 0) && (dump_ptr == '0);
    assign dump_word = dump_zero                  ? '0    :
                       (we && (waddr == dump_ptr)) ? wdata :
                                                    mem[dump_ptr];

    reg_file_dump_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dump_fsm (
        .clk       (clk),
        .reset     (reset),
        .start     (dump.dump_start),
        .ready     (dump.dump_ready),
        .load_data (dump_word),
        .ptr       (dump_ptr),
        .valid     (dump.dump_valid),
        .busy      (dump.dump_busy),
        .addr      (dump.dump_addr),
        .data      (dump.dump_data)
    );

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - randomized self-checking bench for reg_file_param against an array model
module tb_reg_file_param;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int N_RD   = 2;
    localparam int DEPTH  = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;
    logic [N_RD-1:0]        ren;
    logic [N_RD*ADDR_W-1:0] raddr;
    logic [N_RD*DATA_W-1:0] rdata;

    reg_file_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif ();

    reg_file_param #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .N_RD     (N_RD),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .ren   (ren),
        .raddr (raddr),
        .rdata (rdata),
        .dump  (dif)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model  [DEPTH];
    logic [31:0] rd_exp [N_RD];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: predict from the current inputs, then compare both read ports.
    task automatic step();
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            for (int i = 0; i < N_RD; i++) rd_exp[i] = '0;
        end else begin
            for (int i = 0; i < N_RD; i++) begin
                if (ren[i]) begin
                    int a;
                    a = int'(raddr[i*ADDR_W +: ADDR_W]);
                    if (a == 0)                       rd_exp[i] = '0;
                    else if (we && int'(waddr) == a)  rd_exp[i] = wdata;
                    else                              rd_exp[i] = model[a];
                end
            end
            if (we && waddr != '0) model[waddr] = wdata;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N_RD; i++)
            check($sformatf("rdata%0d", i), 64'(rdata[i*DATA_W +: DATA_W]), 64'(rd_exp[i]));
    endtask

    task automatic quiet();
        we = 1'b0; waddr = '0; wdata = '0; ren = '0; raddr = '0;
        dif.dump_start = 1'b0;
    endtask

    task automatic rand_io();
        we    = 1'($urandom_range(0, 1));
        waddr = ADDR_W'($urandom);
        wdata = $urandom;
        ren   = N_RD'($urandom);
        raddr = (N_RD*ADDR_W)'($urandom);
        if ($urandom_range(0, 3) == 0) raddr[ADDR_W-1:0] = waddr;
        if ($urandom_range(0, 3) == 0) raddr[2*ADDR_W-1:ADDR_W] = waddr;
    endtask

    // Run one dump; a beat must show current contents when it first appears and stay put while stalled.
    task automatic run_dump(input int stall_addr, input int stall_len, input int abort_addr, input bit busy_io);
        int   exp_addr;
        int   beats;
        int   stall_cnt;
        int   edges;
        bit   showing;
        bit   aborted;
        logic [ADDR_W-1:0] hold_addr;
        logic [DATA_W-1:0] hold_data;
        exp_addr = 0; beats = 0; stall_cnt = 0; edges = 0; showing = 0; aborted = 0;
        hold_addr = '0; hold_data = '0;
        quiet();
        dif.dump_ready = 1'b1;
        dif.dump_start = 1'b1;
        step();
        dif.dump_start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (dif.dump_valid && !showing) begin
                check("dump_addr", 64'(dif.dump_addr), 64'(exp_addr));
                check("dump_data", 64'(dif.dump_data), 64'(model[dif.dump_addr]));
                hold_addr = dif.dump_addr;
                hold_data = dif.dump_data;
            end else if (dif.dump_valid) begin
                check("dump_hold", {27'(0), dif.dump_addr, dif.dump_data}, {27'(0), hold_addr, hold_data});
            end
            if (abort_addr >= 0 && dif.dump_valid && int'(dif.dump_addr) == abort_addr) begin
                quiet();
                reset = 1'b0;
                step();
                reset = 1'b1;
                check("abort_valid", 64'(dif.dump_valid), 64'(0));
                check("abort_busy", 64'(dif.dump_busy), 64'(0));
                aborted = 1;
                break;
            end
            if (dif.dump_valid && int'(dif.dump_addr) == stall_addr && stall_cnt < stall_len) begin
                dif.dump_ready = 1'b0;
                stall_cnt++;
            end else begin
                dif.dump_ready = 1'b1;
            end
            if (dif.dump_valid && dif.dump_ready) begin
                beats++;
                exp_addr++;
            end
            showing = dif.dump_valid && !dif.dump_ready;
            if (busy_io) begin
                rand_io();
                dif.dump_start = ($urandom_range(0, 7) == 0);
            end else begin
                quiet();
            end
            step();
            edges = cyc + 1;
            if (!dif.dump_busy) break;
        end
        quiet();
        dif.dump_ready = 1'b0;
        if (!aborted) begin
            check("dump_beats", 64'(beats), 64'(DEPTH));
            check("dump_cycles", 64'(edges), 64'(2*DEPTH + stall_len));
        end
    endtask

    initial begin
        reset = 1'b0;
        dif.dump_ready = 1'b0;
        quiet();
        step();
        step();
        check("rst_dump_valid", 64'(dif.dump_valid), 64'(0));
        check("rst_dump_busy", 64'(dif.dump_busy), 64'(0));
        check("rst_dump_addr", 64'(dif.dump_addr), 64'(0));
        check("rst_dump_data", 64'(dif.dump_data), 64'(0));
        reset = 1'b1;

        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        quiet();
        ren = 2'b01; raddr = 10'(5);
        step();
        check("r5_read", 64'(rdata[31:0]), 64'h0000_0000_DEAD_BEEF);

        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; ren = 2'b11; raddr = {5'd7, 5'd7};
        step();
        check("bypass_p0", 64'(rdata[31:0]), 64'h1234_5678);
        check("bypass_p1", 64'(rdata[63:32]), 64'h1234_5678);

        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; ren = 2'b11; raddr = '0;
        step();
        check("r0_bypass", 64'(rdata[31:0]), 64'(0));
        we = 1'b0;
        step();
        check("r0_read", 64'(rdata[63:32]), 64'(0));

        for (int n = 0; n < 300; n++) begin
            rand_io();
            step();
        end
        quiet();

        for (int n = 0; n < DEPTH; n++) begin
            we = 1'b1; waddr = ADDR_W'(n); wdata = 32'(n);
            step();
        end
        quiet();
        run_dump(-1, 0, -1, 1'b0);

        run_dump(3, 5, -1, 1'b1);

        run_dump(-1, 0, 10, 1'b0);
        dif.dump_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            check("post_abort_valid", 64'(dif.dump_valid), 64'(0));
        end
        for (int n = 0; n < DEPTH; n++) begin
            ren = 2'b11; raddr = {ADDR_W'(n), ADDR_W'(DEPTH - 1 - n)};
            step();
            check("post_abort_rd", 64'(rdata), 64'(0));
        end
        quiet();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
